// File: rtl/bus_uart_pkg.sv
// Shared definitions for the sample-word UART path.
//   tx_state_e : per-byte line sequencer state
//   SYNC_BYTE  : marker byte sent ahead of each word when enabled
//   baud_div() : clocks per bit, rounded to nearest
package bus_uart_pkg;

  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam int unsigned WORD_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Clocks per bit; rounding keeps the line rate error below half a clock.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with its own baud counter.
//   clk, rst : clock, synchronous active-high reset
//   start_i  : request to send byte_i; honoured in IDLE or on the last stop-bit clock
//   byte_i   : byte to send, LSB first
//   done_c   : high on the final clock of a stop bit (combinational)
//   tx       : registered line output, idle high
//   busy     : registered, high whenever the sequencer is not idle
module uart_byte_tx
  import bus_uart_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       done_c,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned   CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          wrap;

  assign wrap   = (cnt_q == CNT_MAX);
  assign done_c = (state_q == ST_STOP) && wrap;
  assign tx     = tx_q;
  assign busy   = busy_q;

  // Next-state: bit boundaries only on baud-counter wrap; a start request at
  // the end of a stop bit chains straight into the next start bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start_i) begin
          state_d = ST_START;
          data_d  = byte_i;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (wrap) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      ST_DATA: begin
        if (wrap) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d  = bit_q + 3'd1;
            data_d = {1'b0, data_q[7:1]};
            tx_d   = data_q[1];
          end
        end
      end
      ST_STOP: begin
        if (wrap) begin
          if (start_i) begin
            state_d = ST_START;
            data_d  = byte_i;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/bus_to_uart.sv
// Sample-word to UART bridge: one-word holding buffer in front of a
// byte sequencer that streams each 64-bit word (optionally sync-prefixed)
// over an 8N1 line.
//   clk_50mhz, rst : clock, synchronous active-high reset
//   word_in/valid  : packed samples, byte k = word_in[8k+7:8k]
//   word_ready     : holding buffer empty (combinational from state and rst)
//   tx, busy       : line output (idle high), frame in progress
//   overrun        : one-clock pulse per dropped word
//   drop_cnt       : saturating dropped-word count
module bus_to_uart
  import bus_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 115200,
  parameter bit          SYNC_EN = 1'b1
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [63:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned DIV      = baud_div(CLK_HZ, BAUD);
  localparam int unsigned NBYTES   = WORD_BYTES + 32'(SYNC_EN);
  localparam logic [3:0]  LAST_IDX = 4'(NBYTES - 1);

  logic [63:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [63:0] shift_q, shift_d;
  logic [3:0]  idx_q, idx_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  drop_q, drop_d;

  logic        accept_c;
  logic        load_c;
  logic        next_c;
  logic        start_c;
  logic [7:0]  byte_c;
  logic        tx_done_c;
  logic        tx_busy;

  assign word_ready = !hold_full_q && !rst;
  assign accept_c   = word_valid && word_ready;
  // Another byte of the active word follows this stop bit.
  assign next_c     = tx_done_c && (idx_q != LAST_IDX);
  // Start a new word from the hold buffer: when idle, or seamlessly after the
  // last stop bit of the previous word.
  assign load_c     = hold_full_q && (!tx_busy || (tx_done_c && (idx_q == LAST_IDX)));
  assign start_c    = !rst && (load_c || next_c);

  assign overrun  = overrun_q;
  assign drop_cnt = drop_q;

  // Hold buffer, byte sequencing and drop accounting.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    byte_c      = shift_q[7:0];

    if (accept_c) begin
      hold_d      = word_in;
      hold_full_d = 1'b1;
    end

    if (next_c) begin
      byte_c  = shift_q[7:0];
      shift_d = {8'h00, shift_q[63:8]};
      idx_d   = idx_q + 4'd1;
    end else if (load_c) begin
      hold_full_d = 1'b0;
      idx_d       = '0;
      if (SYNC_EN) begin
        byte_c  = SYNC_BYTE;
        shift_d = hold_q;
      end else begin
        byte_c  = hold_q[7:0];
        shift_d = {8'h00, hold_q[63:8]};
      end
    end

    overrun_d = word_valid && hold_full_q;
    drop_d    = drop_q;
    if (overrun_d && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
    end
  end

  uart_byte_tx #(
    .DIV (DIV)
  ) u_byte_tx (
    .clk     (clk_50mhz),
    .rst     (rst),
    .start_i (start_c),
    .byte_i  (byte_c),
    .done_c  (tx_done_c),
    .tx      (tx),
    .busy    (tx_busy)
  );

  assign busy = tx_busy;

endmodule

// File: tb/tb_bus_to_uart.sv
// Bench for bus_to_uart: two instances (sync prefix on / off) share stimulus.
// Line activity is logged every clock and compared against an ideal 8N1
// waveform built from the expected byte list.
module tb_bus_to_uart;

  localparam int unsigned DIV  = 4;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk;
  logic        rst;
  logic [63:0] word_in;
  logic        word_valid;
  logic        rdy_s, tx_s, busy_s, ovr_s;
  logic [7:0]  drop_s;
  logic        rdy_n, tx_n, busy_n, ovr_n;
  logic [7:0]  drop_n;

  int n_chk  = 0;
  int n_fail = 0;

  bit txs_log[$];
  bit txn_log[$];
  bit busys_log[$];
  bit busyn_log[$];
  int ovr_cnt_s;
  int ovr_cnt_n;
  logic [7:0] exp_s_q[$];
  logic [7:0] exp_n_q[$];

  typedef struct {
    logic [63:0] word;
    int          busy_s;
    int          busy_n;
    logic [7:0]  first_s;
    logic [7:0]  first_n;
  } vec_t;
  vec_t vecs[5];

  bus_to_uart #(.CLK_HZ(1000), .BAUD(250), .SYNC_EN(1'b1)) dut_s (
    .clk_50mhz (clk), .rst (rst), .word_in (word_in), .word_valid (word_valid),
    .word_ready (rdy_s), .tx (tx_s), .busy (busy_s), .overrun (ovr_s), .drop_cnt (drop_s)
  );

  bus_to_uart #(.CLK_HZ(1000), .BAUD(250), .SYNC_EN(1'b0)) dut_n (
    .clk_50mhz (clk), .rst (rst), .word_in (word_in), .word_valid (word_valid),
    .word_ready (rdy_n), .tx (tx_n), .busy (busy_n), .overrun (ovr_n), .drop_cnt (drop_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    txs_log.push_back(tx_s);
    txn_log.push_back(tx_n);
    busys_log.push_back(busy_s);
    busyn_log.push_back(busy_n);
    if (ovr_s) ovr_cnt_s++;
    if (ovr_n) ovr_cnt_n++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    txs_log.delete();
    txn_log.delete();
    busys_log.delete();
    busyn_log.delete();
    exp_s_q.delete();
    exp_n_q.delete();
    ovr_cnt_s = 0;
    ovr_cnt_n = 0;
  endtask

  task automatic do_reset();
    word_valid = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Present one word for one clock.
  task automatic present(input logic [63:0] w);
    word_in    = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  // Reference model: bytes the host should receive for a word.
  task automatic add_word(input logic [63:0] w);
    exp_s_q.push_back(SYNC);
    for (int k = 0; k < 8; k++) begin
      exp_s_q.push_back(w[8*k +: 8]);
      exp_n_q.push_back(w[8*k +: 8]);
    end
  endtask

  function automatic int first_low(input bit sel);
    bit l[$];
    if (sel) l = txn_log; else l = txs_log;
    foreach (l[i]) if (l[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int count_busy(input bit sel);
    bit l[$];
    int c = 0;
    if (sel) l = busyn_log; else l = busys_log;
    foreach (l[i]) if (l[i]) c++;
    return c;
  endfunction

  // Sample byte k of the received stream at mid-bit.
  function automatic logic [7:0] decode(input bit sel, input int k);
    bit l[$];
    logic [7:0] r = '0;
    int i0 = first_low(sel);
    int p;
    if (sel) l = txn_log; else l = txs_log;
    if (i0 < 0) return 8'hXX;
    for (int b = 0; b < 8; b++) begin
      p = i0 + k * 10 * DIV + DIV * (b + 1) + DIV / 2;
      if (p < l.size()) r[b] = l[p];
    end
    return r;
  endfunction

  // Compare logged line against an ideal gap-free 8N1 stream of the expected bytes.
  task automatic analyze(input string name, input bit sel);
    bit l[$];
    bit bits[$];
    logic [7:0] eb[$];
    int i0, mism, tail;
    if (sel) begin l = txn_log; eb = exp_n_q; end
    else     begin l = txs_log; eb = exp_s_q; end
    foreach (eb[k]) begin
      for (int r = 0; r < DIV; r++) bits.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int r = 0; r < DIV; r++) bits.push_back(eb[k][b]);
      for (int r = 0; r < DIV; r++) bits.push_back(1'b1);
    end
    i0 = first_low(sel);
    chk({name, "_start_seen"}, (i0 >= 0) ? 1 : 0, 1);
    if (i0 < 0) i0 = 0;
    mism = 0;
    foreach (bits[j]) if ((i0 + j >= l.size()) || (l[i0 + j] != bits[j])) mism++;
    tail = 0;
    for (int k = i0 + bits.size(); k < l.size(); k++) if (!l[k]) tail++;
    chk({name, "_wave_mismatch_clks"}, mism, 0);
    chk({name, "_low_after_end"}, tail, 0);
    chk({name, "_busy_clks"}, count_busy(sel), bits.size());
  endtask

  initial begin
    logic [63:0] w1, w2;
    int two;

    vecs[0] = '{64'h0706050403020100, 360, 320, 8'hA5, 8'h00};
    vecs[1] = '{64'hFFFF0000AAAA5555, 360, 320, 8'hA5, 8'h55};
    vecs[2] = '{64'h0000000000000000, 360, 320, 8'hA5, 8'h00};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 360, 320, 8'hA5, 8'hFF};
    vecs[4] = '{64'h80017FFEC33CA55A, 360, 320, 8'hA5, 8'h5A};

    word_in = '0;
    word_valid = 1'b0;
    rst = 1'b1;

    // Reset state
    tick(3);
    chk("rst_ready_low", rdy_s, 0);
    chk("rst_tx", tx_s, 1);
    chk("rst_busy", busy_s, 0);
    chk("rst_overrun", ovr_s, 0);
    chk("rst_drop", drop_s, 0);
    chk("rst_tx_n", tx_n, 1);
    rst = 1'b0;
    #1;
    chk("rel_ready", rdy_s, 1);
    tick(1);

    // Single words from the table: latency, waveform, busy length, first byte
    for (int v = 0; v < 5; v++) begin
      do_reset();
      clear_logs();
      add_word(vecs[v].word);
      present(vecs[v].word);
      chk($sformatf("v%0d_tx_after_accept", v), tx_s, 1);
      chk($sformatf("v%0d_ready_after_accept", v), rdy_s, 0);
      tick(1);
      chk($sformatf("v%0d_tx_start_bit", v), tx_s, 0);
      chk($sformatf("v%0d_busy_start", v), busy_s, 1);
      chk($sformatf("v%0d_ready_after_xfer", v), rdy_s, 1);
      tick(360 + 30);
      analyze($sformatf("v%0d_s", v), 1'b0);
      analyze($sformatf("v%0d_n", v), 1'b1);
      chk($sformatf("v%0d_busy_s_tbl", v), count_busy(1'b0), vecs[v].busy_s);
      chk($sformatf("v%0d_busy_n_tbl", v), count_busy(1'b1), vecs[v].busy_n);
      chk($sformatf("v%0d_first_s", v), decode(1'b0, 0), vecs[v].first_s);
      chk($sformatf("v%0d_first_n", v), decode(1'b1, 0), vecs[v].first_n);
    end

    // Two words, second offered mid-frame: accepted at once, no gap
    do_reset();
    clear_logs();
    w1 = 64'h1122334455667788;
    w2 = 64'h99AABBCCDDEEFF00;
    add_word(w1);
    add_word(w2);
    present(w1);
    tick(50);
    chk("two_ready_mid", rdy_s, 1);
    present(w2);
    chk("two_second_taken", rdy_s, 0);
    tick(720 + 40);
    analyze("two_s", 1'b0);
    analyze("two_n", 1'b1);
    chk("two_overrun_s", ovr_cnt_s, 0);
    chk("two_overrun_n", ovr_cnt_n, 0);

    // Three words while busy: third dropped
    do_reset();
    clear_logs();
    w1 = 64'h0F0E0D0C0B0A0908;
    w2 = 64'h1716151413121110;
    add_word(w1);
    add_word(w2);
    present(w1);
    tick(1);
    present(w2);
    present(64'hDEADBEEFCAFEF00D);
    chk("three_overrun_pulse", ovr_s, 1);
    chk("three_drop", drop_s, 1);
    tick(1);
    chk("three_overrun_one_clk", ovr_s, 0);
    tick(720 + 40);
    analyze("three_s", 1'b0);
    analyze("three_n", 1'b1);
    chk("three_ovr_cnt_s", ovr_cnt_s, 1);
    chk("three_drop_n", drop_n, 1);

    // Reset during bit 3 of byte 2; held word and drop count are lost
    do_reset();
    clear_logs();
    present(64'h0706050403020100);
    tick(1);
    present(64'h2222222222222222);
    present(64'h3333333333333333);
    chk("mid_drop_before", drop_s, 1);
    tick(95);
    chk("mid_tx_bit3", tx_s, 0);
    rst = 1'b1;
    tick(1);
    chk("mid_tx_after_rst", tx_s, 1);
    chk("mid_busy_after_rst", busy_s, 0);
    chk("mid_drop_after_rst", drop_s, 0);
    chk("mid_ovr_after_rst", ovr_s, 0);
    chk("mid_busy_n_after_rst", busy_n, 0);
    chk("mid_drop_n_after_rst", drop_n, 0);
    chk("mid_ready_in_rst", rdy_s, 0);
    rst = 1'b0;
    #1;
    chk("mid_ready_release", rdy_s, 1);
    clear_logs();
    tick(60);
    chk("mid_held_word_lost_s", first_low(1'b0), -1);
    chk("mid_held_word_lost_n", first_low(1'b1), -1);
    clear_logs();
    w1 = 64'h5A5A00FF12345678;
    add_word(w1);
    present(w1);
    tick(360 + 30);
    analyze("mid_new_s", 1'b0);
    analyze("mid_new_n", 1'b1);

    // 300 words with valid held high: counter saturates
    do_reset();
    clear_logs();
    present(64'hA5A5A5A5A5A5A5A5);
    tick(1);
    word_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      word_in = {$urandom, $urandom};
      @(negedge clk);
    end
    word_valid = 1'b0;
    tick(5);
    chk("sat_drop_s", drop_s, 255);
    chk("sat_drop_n", drop_n, 255);
    chk("sat_ovr_cnt_s", ovr_cnt_s, 299);
    chk("sat_ovr_cnt_n", ovr_cnt_n, 299);
    present(64'h1);
    tick(2);
    chk("sat_hold_255", drop_s, 255);

    // Random words, one or two per run
    for (int r = 0; r < 6; r++) begin
      do_reset();
      clear_logs();
      w1  = {$urandom, $urandom};
      two = $urandom_range(0, 1);
      add_word(w1);
      present(w1);
      if (two != 0) begin
        tick($urandom_range(1, 150));
        w2 = {$urandom, $urandom};
        add_word(w2);
        present(w2);
      end
      tick(2 * 360 + 40);
      analyze($sformatf("rnd%0d_s", r), 1'b0);
      analyze($sformatf("rnd%0d_n", r), 1'b1);
      chk($sformatf("rnd%0d_no_overrun", r), ovr_cnt_s + ovr_cnt_n, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
